leaf_stream_packetizer: RTL and testbench

- Transmit side of the leaf-to-BFT link.
- Accepts 32-bit user stream words on a valid/ready handshake and wraps each word in a 49-bit BFT packet with destination leaf, port and BRAM write address.
- Drives dout_leaf_interface2bft.
- Sends only while it holds freespace credits. Credits are returned by freespace-update packets arriving on din_leaf_bft2interface. Packets held during resend are retried afterwards.

---
 rtl/leaf_pkt_pkg.sv | 30 +++
 rtl/leaf_skid_fifo.sv | 60 ++++++
 rtl/leaf_stream_packetizer.sv | 97 +++++++++
 tb/tb_leaf_stream_packetizer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Shared field layout and packet builder for the leaf-to-BFT transmit path.
package leaf_pkt_pkg;

  localparam int unsigned PACKET_BITS        = 49;
  localparam int unsigned PAYLOAD_BITS       = 32;
  localparam int unsigned NUM_LEAF_BITS      = 5;
  localparam int unsigned NUM_PORT_BITS      = 4;
  localparam int unsigned NUM_ADDR_BITS      = 7;
  localparam int unsigned NUM_BRAM_ADDR_BITS = 7;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_LSB  = 43;
  localparam int unsigned PORT_LSB  = 39;
  localparam int unsigned ADDR_LSB  = 32;

  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

  localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned MAX_CREDITS = 1 << NUM_BRAM_ADDR_BITS;

  function automatic logic [PACKET_BITS-1:0] pkt_build(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    pkt_build = {1'b1, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_skid_fifo.sv
// Two-entry fall-through FIFO: an arriving word is visible on the output the same
// cycle when the FIFO is empty, so a waiting consumer loses no cycle.
module leaf_skid_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push, pop, bypass, store, drain;

  always_comb begin
    in_ready_o  = (count_q != 2'd2);
    out_valid_o = (count_q != 2'd0) || in_valid_i;
    out_data_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : in_data_i;

    push   = in_valid_i && in_ready_o;
    pop    = out_valid_o && out_ready_i;
    bypass = pop && (count_q == 2'd0);
    store  = push && !bypass;
    drain  = pop && (count_q != 2'd0);

    mem_d = mem_q;
    if (store) begin
      mem_d[wr_ptr_q] = in_data_i;
    end
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ drain;
    count_d  = count_q + 2'(store) - 2'(drain);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Wraps user stream words into BFT packets, gated by remote-buffer credits that are
// returned by freespace-update packets from the network.
module leaf_stream_packetizer
  import leaf_pkt_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [CREDIT_BITS-1:0]   credits,
  output logic                     credit_err
);

  logic [PAYLOAD_BITS-1:0]  head_data;
  logic                     head_valid;
  logic                     load, consume, credit_pkt;
  logic [7:0]               credit_ret;
  logic [9:0]               credit_sum;

  logic                     out_valid_q, out_valid_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [CREDIT_BITS-1:0]   credits_q, credits_d;
  logic                     credit_err_q, credit_err_d;

  leaf_skid_fifo #(
    .Width(PAYLOAD_BITS)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_data_i  (din_leaf_user2interface),
    .in_valid_i (vld_user2interface),
    .in_ready_o (ack_interface2user),
    .out_data_o (head_data),
    .out_valid_o(head_valid),
    .out_ready_i(load)
  );

  always_comb begin
    consume    = out_valid_q && !resend;
    load       = head_valid && (credits_q != '0) && (!out_valid_q || consume);
    credit_pkt = din_leaf_bft2interface[VALID_BIT] &&
                 (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);
    credit_ret = credit_pkt ? din_leaf_bft2interface[7:0] : 8'd0;

    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;
    if (load) begin
      out_valid_d = 1'b1;
      pkt_d       = pkt_build(dest_leaf, dest_port, wr_addr_q, head_data);
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    wr_addr_d = wr_addr_q + NUM_ADDR_BITS'(load);

    // load only fires with credits_q != 0, so the subtraction cannot underflow.
    credit_sum   = 10'(credits_q) - 10'(load) + 10'(credit_ret);
    credit_err_d = credit_err_q;
    if (credit_sum > 10'(MAX_CREDITS)) begin
      credits_d    = CREDIT_BITS'(MAX_CREDITS);
      credit_err_d = 1'b1;
    end else begin
      credits_d = credit_sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      pkt_q        <= '0;
      wr_addr_q    <= '0;
      credits_q    <= CREDIT_BITS'(MAX_CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      pkt_q        <= pkt_d;
      wr_addr_q    <= wr_addr_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign dout_leaf_interface2bft = (out_valid_q && !resend && !reset) ? pkt_q : '0;
  assign credits                 = credits_q;
  assign credit_err              = credit_err_q;

  // Only the valid bit, port field and credit byte of incoming packets matter here.
  logic unused_din;
  assign unused_din = ^{din_leaf_bft2interface[47:43], din_leaf_bft2interface[38:8]};

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized scoreboard bench for leaf_stream_packetizer: the driver queues expected
// packets on acceptance, a negedge monitor pops and compares every sent packet.
module tb_leaf_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din_user = '0;
  logic        vld = 1'b0;
  logic        ack;
  logic [4:0]  dest_leaf = '0;
  logic [3:0]  dest_port = '0;
  logic [48:0] din_bft = '0;
  logic [48:0] dout;
  logic        resend = 1'b0;
  logic [7:0]  credits;
  logic        credit_err;

  int vectors = 0;
  int miscompares = 0;

  logic [48:0] exp_q[$];
  int          sent_total = 0;
  int          addr_base = 0;
  int          sent_mark = 0;
  int          cred_acc = 128;
  bit          err_model = 1'b0;
  bit          noise_on = 1'b0;
  logic [48:0] mon_exp;

  leaf_stream_packetizer dut (
    .clk                    (clk),
    .reset                  (reset),
    .din_leaf_user2interface(din_user),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .dest_leaf              (dest_leaf),
    .dest_port              (dest_port),
    .din_leaf_bft2interface (din_bft),
    .dout_leaf_interface2bft(dout),
    .resend                 (resend),
    .credits                (credits),
    .credit_err             (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk(input logic [31:0] w);
    return {1'b1, dest_leaf, dest_port, 7'd0, w};
  endfunction

  // Credits the DUT should hold once every loaded packet has also been sent.
  function automatic int exp_credits();
    return cred_acc - (sent_total - sent_mark);
  endfunction

  // Advance to just after the next rising edge; optionally inject network noise.
  task automatic step();
    @(posedge clk);
    #1;
    if (noise_on) begin
      resend = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: din_bft = '0;
        1: din_bft = {1'b1, 5'($urandom), 4'($urandom_range(1, 15)), 7'($urandom),
                      32'($urandom)};
        default: din_bft = {1'b0, 5'($urandom), 4'd0, 7'($urandom),
                            32'($urandom) | 32'hFF};
      endcase
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int budget);
    din_user = w;
    vld = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (ack) begin
        exp_q.push_back(mk(w));
        step();
        vld = 1'b0;
        return;
      end
      step();
    end
    check("push_timeout", ack, 1);
    vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 0);
    step();
  endtask

  task automatic credit_return(input int r);
    int cur;
    din_bft = {1'b1, 5'd0, 4'd0, 7'd0, 24'd0, 8'(r)};
    cur = exp_credits() + r;
    if (cur > 128) begin
      cur = 128;
      err_model = 1'b1;
    end
    cred_acc = cur;
    sent_mark = sent_total;
    step();
    din_bft = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    vld = 1'b0;
    resend = 1'b0;
    din_bft = '0;
    exp_q.delete();
    #1;
    check("dout_in_reset", dout, 0);
    repeat (n) step();
    reset = 1'b0;
    addr_base = sent_total;
    sent_mark = sent_total;
    cred_acc = 128;
    err_model = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (!reset && dout !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", dout, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_exp[38:32] = 7'((sent_total - addr_base) % 128);
        check("packet", dout, mon_exp);
      end
      sent_total++;
    end
  end

  initial begin
    int accepted;
    step();
    do_reset(3);
    check("rst_credits", credits, 128);
    check("rst_ack", ack, 1);
    check("rst_err", credit_err, 0);
    check("rst_dout", dout, 0);

    // Single word, one-cycle latency.
    dest_leaf = 5'd12;
    dest_port = 4'd1;
    push_word(32'hDEADBEEF, 10);
    check("single_dout", dout, 49'h1_6080_DEAD_BEEF);
    step();
    check("single_idle", dout, 0);
    check("single_credits", credits, exp_credits());

    // Random stream with random resend and non-credit traffic on the input link.
    dest_leaf = 5'($urandom);
    dest_port = 4'($urandom);
    noise_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push_word($urandom, 200);
      repeat ($urandom_range(0, 2)) step();
    end
    noise_on = 1'b0;
    resend = 1'b0;
    din_bft = '0;
    drain();
    check("rand_credits", credits, exp_credits());
    check("rand_err", credit_err, 0);

    // Credit exhaustion from a fresh reset, then a two-credit return.
    do_reset(2);
    dest_leaf = 5'd3;
    dest_port = 4'd7;
    accepted = 0;
    vld = 1'b1;
    for (int c = 0; c < 400 && accepted < 130; c++) begin
      din_user = $urandom;
      if (ack) begin
        exp_q.push_back(mk(din_user));
        accepted++;
      end
      step();
    end
    vld = 1'b0;
    check("exh_accepted", accepted, 130);
    repeat (3) step();
    check("exh_ack", ack, 0);
    check("exh_credits", credits, 0);
    check("exh_sent", sent_total - addr_base, 128);
    check("exh_idle", dout, 0);
    credit_return(2);
    drain();
    check("ret_sent", sent_total - addr_base, 130);
    check("ret_credits", credits, exp_credits());

    // Resend hold: packet is held, credits move once, packet sent once.
    credit_return(3);
    resend = 1'b1;
    push_word(32'hCAFE0001, 20);
    for (int i = 0; i < 3; i++) begin
      check("resend_hold", dout, 0);
      check("resend_credits", credits, exp_credits() - 1);
      step();
    end
    resend = 1'b0;
    drain();
    check("resend_sent", sent_total - addr_base, 131);
    check("resend_after", credits, exp_credits());

    // Load and return in the same cycle at credits == 1.
    push_word(32'h1234_5678, 20);
    drain();
    check("pre_sim_credits", credits, exp_credits());
    din_user = $urandom;
    vld = 1'b1;
    check("sim_ack", ack, 1);
    exp_q.push_back(mk(din_user));
    credit_return(5);
    vld = 1'b0;
    drain();
    check("sim_credits", credits, exp_credits());

    // Overflow saturates and sets the sticky error.
    credit_return(122);
    step();
    check("pre_ovf_credits", credits, exp_credits());
    check("pre_ovf_err", credit_err, err_model);
    credit_return(4);
    step();
    check("ovf_credits", credits, exp_credits());
    check("ovf_err", credit_err, err_model);
    repeat (5) step();
    check("ovf_err_sticky", credit_err, err_model);

    // Reset with a held packet and a queued word discards both.
    resend = 1'b1;
    push_word($urandom, 20);
    push_word($urandom, 20);
    step();
    do_reset(2);
    check("mid_rst_credits", credits, 128);
    check("mid_rst_err", credit_err, 0);
    check("mid_rst_ack", ack, 1);
    check("mid_rst_dout", dout, 0);
    push_word(32'h0BAD_F00D, 10);
    drain();
    check("mid_rst_sent", sent_total - addr_base, 1);
    check("post_rst_credits", credits, exp_credits());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
